// File: rtl/cookie_pkg.sv
// Shared types and constants for cookie_jar: FSM state type, depth helper,
// and known-good LFSR taps/seeds for the common cookie widths.
package cookie_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cookie_state_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] SEED_W16 = 16'h0001;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [31:0] SEED_W32 = 32'h0000_0001;
  localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_W64 = 64'h0000_0000_0000_0001;

  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < depth) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cookie_lfsr.sv
// cookie_lfsr: Fibonacci LFSR, shifts left with XOR-reduced tapped bits into bit 0.
// A zero state can only come from a bad seed; it recovers to SEED on the next enabled cycle.
module cookie_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (state_q == '0) state_d = SEED;
      else               state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign q_o = state_q;

endmodule

// File: rtl/cookie_jar.sv
// cookie_jar: serial-in cookie FIFO emitting raw or LFSR-scrambled serial frames.
// Define COOKIE_PARITY_EN to append an even-parity bit (over the sent word) to every frame.
//   state | meaning
//   IDLE  | waiting for display/run with a buffered cookie
//   SHIFT | emitting frame bits, LSB first, one per enabled cycle
module cookie_jar
  import cookie_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_W8)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        run_i,
  input  logic                        display_i,
  input  logic                        in_bit_i,
  input  logic                        in_valid_i,
  output logic                        out_bit_o,
  output logic                        out_valid_o,
  output logic                        out_last_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [clog2_depth(DEPTH):0] count_o,
  output logic                        overflow_o,
  output logic [WIDTH-1:0]            lfsr_q_o
);

  localparam int AW = clog2_depth(DEPTH);
  localparam int BW = $clog2(WIDTH);
`ifdef COOKIE_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int FW = $clog2(FRAME);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [0:0]  S_IDLE   = 1'(IDLE);
  localparam logic [0:0]  S_SHIFT  = 1'(SHIFT);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             overflow_q, overflow_d;
  logic [0:0]       state_q, state_d;
  logic [FRAME-1:0] shreg_q, shreg_d;
  logic [FW-1:0]    remain_q, remain_d;
  logic             out_bit_q, out_bit_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             push_req, push_ok, pop;
  logic [WIDTH-1:0] push_word, tx_word, lfsr_q;
  logic [FRAME-1:0] frame_word;

  cookie_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .q_o   (lfsr_q)
  );

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign pop      = en_i && (state_q == S_IDLE) && (display_i || run_i) && !empty_o;
  assign push_req = en_i && in_valid_i && (bitcnt_q == BW'(WIDTH-1));
  assign push_ok  = push_req && (!full_o || pop);
  // lfsr_q here is the pre-advance value of the pop edge
  assign tx_word  = display_i ? mem_q[rd_ptr_q] : (mem_q[rd_ptr_q] ^ lfsr_q);
`ifdef COOKIE_PARITY_EN
  assign frame_word = {^tx_word, tx_word};
`else
  assign frame_word = tx_word;
`endif

  always_comb begin
    push_word           = asm_q;
    push_word[bitcnt_q] = in_bit_i;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    asm_d       = asm_q;
    bitcnt_d    = bitcnt_q;
    overflow_d  = overflow_q;
    state_d     = state_q;
    shreg_d     = shreg_q;
    remain_d    = remain_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (en_i) begin
      if (in_valid_i) begin
        if (push_req) begin
          asm_d    = '0;
          bitcnt_d = '0;
        end else begin
          asm_d    = push_word;
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_req && !push_ok) overflow_d = 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push_ok) count_d = count_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_d     = S_SHIFT;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_bit_d   = frame_word[0];
            shreg_d     = frame_word >> 1;
            remain_d    = FW'(FRAME-1);
          end
        end
        default: begin
          if (remain_q == '0) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_bit_d   = 1'b0;
          end else begin
            remain_d   = remain_q - 1'b1;
            out_bit_d  = shreg_q[0];
            shreg_d    = shreg_q >> 1;
            out_last_d = (remain_q == FW'(1));
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      bitcnt_q    <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      remain_q    <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      bitcnt_q    <= bitcnt_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      remain_q    <= remain_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign out_bit_o   = out_bit_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign lfsr_q_o    = lfsr_q;

endmodule
